// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage RV32I pipeline: forwarding selects,
// stall/flush steering, data-memory wait FSM with timeout, and saturating perf counters.
module hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       rs1_d,
   input  logic [4:0]       rs2_d,
   input  logic [4:0]       rs1_e,
   input  logic [4:0]       rs2_e,
   input  logic [4:0]       rd_e,
   input  logic [4:0]       rd_m,
   input  logic [4:0]       rd_w,
   input  logic [1:0]       ResultSrc_e,
   input  logic             RegWrite_m,
   input  logic             RegWrite_w,
   input  logic             PCSrc_e,
   input  logic             MemRead_m,
   input  logic             MemWrite_m,
   input  logic             dmem_ready,
   output logic             stall_f,
   output logic             stall_d,
   output logic             flush_d,
   output logic             stall_e,
   output logic             flush_e,
   output logic             stall_m,
   output logic             flush_w,
   output logic             dmem_req,
   output logic [1:0]       ForwardA_e,
   output logic [1:0]       ForwardB_e,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int unsigned TW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TW-1:0] LAST = TW'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_WAIT  = 2'd1,
      S_ERROR = 2'd2
   } state_t;

   state_t        state, state_n;
   logic [TW-1:0] cnt, cnt_n;
   logic          mem_op;
   logic          mem_stall;
   logic          lw_stall;

   // M-stage producer wins over W-stage; x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
      logic [1:0] sel;
      sel = 2'b00;
      if (RegWrite_m && (rd_m != 5'd0) && (rd_m == rs))
         sel = 2'b10;
      else if (RegWrite_w && (rd_w != 5'd0) && (rd_w == rs))
         sel = 2'b01;
      return sel;
   endfunction

   assign ForwardA_e = fwd_sel(rs1_e);
   assign ForwardB_e = fwd_sel(rs2_e);

   assign mem_op    = MemRead_m | MemWrite_m;
   assign mem_stall = (mem_op && !dmem_ready) || (state == S_ERROR);
   assign lw_stall  = (ResultSrc_e == 2'b01) && (rd_e != 5'd0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));

   assign dmem_req    = mem_op;
   assign mem_timeout = (state == S_ERROR);

   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      flush_w = 1'b0;
      if (mem_stall) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         flush_w = 1'b1;
      end else begin
         // A taken branch overrides load-use so the target PC can load.
         flush_d = PCSrc_e;
         flush_e = PCSrc_e | lw_stall;
         stall_f = lw_stall & ~PCSrc_e;
         stall_d = lw_stall & ~PCSrc_e;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         S_RUN: begin
            if (mem_op && !dmem_ready) begin
               state_n = (MEM_TIMEOUT <= 1) ? S_ERROR : S_WAIT;
               cnt_n   = TW'(1);
            end else begin
               cnt_n = '0;
            end
         end
         S_WAIT: begin
            if (!mem_op || dmem_ready) begin
               state_n = S_RUN;
               cnt_n   = '0;
            end else if (cnt >= LAST) begin
               state_n = S_ERROR;
            end else begin
               cnt_n = cnt + TW'(1);
            end
         end
         S_ERROR: begin
            state_n = S_ERROR;
         end
         default: begin
            state_n = S_RUN;
            cnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_RUN;
         cnt       <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (stall_f && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (PCSrc_e && !mem_stall && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RV32I pipeline.
- Drives the enable/clear inputs of the F/D, D/E, E/M and M/W pipeline registers and the PC hold.
- Generates E-stage forwarding selects.
- Runs a data-memory wait FSM with timeout detection, plus saturating stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 64, max consecutive wait cycles on one dmem access before error.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rs1_d  in  5  D-stage source reg 1
- rs2_d  in  5  D-stage source reg 2
- rs1_e  in  5  E-stage source reg 1
- rs2_e  in  5  E-stage source reg 2
- rd_e  in  5  E-stage dest reg
- rd_m  in  5  M-stage dest reg
- rd_w  in  5  W-stage dest reg
- ResultSrc_e  in  2  E-stage result select; 2'b01 = load
- RegWrite_m  in  1  M-stage writes RF
- RegWrite_w  in  1  W-stage writes RF
- PCSrc_e  in  1  taken branch/jump resolved in E
- MemRead_m  in  1  load in M
- MemWrite_m  in  1  store in M
- dmem_ready  in  1  data memory completes access this cycle
- stall_f  out  1  hold PC
- stall_d  out  1  deassert F/D enable
- flush_d  out  1  F/D clear
- stall_e  out  1  deassert D/E enable
- flush_e  out  1  D/E clear
- stall_m  out  1  deassert E/M enable
- flush_w  out  1  M/W clear (bubble)
- dmem_req  out  1  data memory request
- ForwardA_e  out  2  operand A select
- ForwardB_e  out  2  operand B select
- mem_timeout  out  1  sticky timeout error
- stall_cnt  out  CNT_W  cycles with stall_f asserted
- flush_cnt  out  CNT_W  taken-branch flushes

Behaviour:
Forwarding (combinational):
- ForwardA_e = 2'b10 if RegWrite_m && rd_m!=0 && rd_m==rs1_e.
- Otherwise 2'b01 if RegWrite_w && rd_w!=0 && rd_w==rs1_e.
- Otherwise 2'b00.
- ForwardB_e is identical using rs2_e.
- M-stage match has priority over W-stage match.

Hazard terms:
- mem_op = MemRead_m | MemWrite_m.
- dmem_req = mem_op, held until the cycle dmem_ready is sampled high.
- mem_stall = (mem_op && !dmem_ready) | (state==ERROR).
- lw_stall = ResultSrc_e==2'b01 && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).

Priority when mem_stall is asserted:
- stall_f, stall_d, stall_e, stall_m = 1 and flush_w = 1.
- flush_d and flush_e = 0; the branch/load-use is re-evaluated when the pipeline is released.

Priority when mem_stall is deasserted:
- flush_d = PCSrc_e.
- flush_e = PCSrc_e | lw_stall.
- stall_f = stall_d = lw_stall && !PCSrc_e (a taken branch overrides load-use so the target PC loads).
- stall_e = stall_m = flush_w = 0.

FSM (state register, cnt register sized for MEM_TIMEOUT):
- RUN: if mem_op && !dmem_ready -> WAIT, cnt=1. Else stay in RUN. A zero-wait access costs no stall cycle.
- WAIT: if dmem_ready -> RUN, cnt=0, and stall is released that same cycle. Else if cnt==MEM_TIMEOUT-1 -> ERROR. Else cnt+1.
- ERROR: terminal. mem_timeout=1 and the pipeline stays frozen until rst_n.
- mem_op dropping in WAIT (should not happen) -> RUN.

Counters (registered, saturating at all-ones):
- stall_cnt increments each cycle stall_f=1.
- flush_cnt increments each cycle PCSrc_e && !mem_stall.

Reset (rst_n=0 at posedge):
- state=RUN, cnt=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
- Combinational outputs follow the inputs.
- Reset mid-WAIT abandons the access: dmem_req follows mem_op, which the pipeline registers clear on reset.

Test Plan:
- Back-to-back: add x5 in M, x5 in W, rs1_e=5 -> ForwardA_e=2'b10. Same with rs1_e=0 -> 2'b00.
- Load-use: ResultSrc_e=01, rd_e=7, rs2_d=7 -> stall_f=stall_d=flush_e=1 for exactly 1 cycle; stall_cnt +1.
- Branch with load-use: PCSrc_e=1 and lw_stall=1 -> flush_d=flush_e=1, stall_f=0; flush_cnt +1.
- Memory wait: MemRead_m=1, dmem_ready low 3 cycles then high -> stall_f/d/e/m and flush_w high exactly 3 cycles; state returns to RUN on the 4th cycle; PCSrc_e asserted during the wait produces no flush.
- Timeout: MEM_TIMEOUT=4, dmem_ready held low -> mem_timeout=1 after 4 wait cycles; stalls persist; rst_n low for 1 cycle clears everything to reset values.
- Saturation: CNT_W=3, 10 load-use stalls -> stall_cnt holds at 7.
